// File: rtl/muntjac_tl_ram_device_pkg.sv
// muntjac_tl_ram_device_pkg: TileLink opcodes and burst helpers shared by the RAM device.
package muntjac_tl_ram_device_pkg;

    localparam int unsigned SizeWidth = 3;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        ArithmeticData = 3'h2,
        LogicalData    = 3'h3,
        Get            = 3'h4,
        Intent         = 3'h5,
        AcquireBlock   = 3'h6,
        AcquirePerm    = 3'h7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1,
        HintAck       = 3'h2,
        Grant         = 3'h4,
        GrantData     = 3'h5,
        ReleaseAck    = 3'h6
    } tl_d_op_e;

    // Beats in a 64-bit-wide message of 2^size bytes.
    function automatic logic [4:0] tl_beats(input logic [SizeWidth-1:0] size);
        return size > 3'd3 ? 5'd1 << (size - 3'd3) : 5'd1;
    endfunction

endpackage

// File: rtl/tl_channel.sv
// tl_channel: TileLink A-E channel bundle with host and device views.
interface tl_channel
    import muntjac_tl_ram_device_pkg::*;
#(
    parameter int unsigned AddrWidth   = 56,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned SourceWidth = 4,
    parameter int unsigned SinkWidth   = 1
);
    logic                   a_valid, a_ready, a_corrupt;
    logic [2:0]             a_opcode, a_param;
    logic [SizeWidth-1:0]   a_size;
    logic [SourceWidth-1:0] a_source;
    logic [AddrWidth-1:0]   a_address;
    logic [DataWidth/8-1:0] a_mask;
    logic [DataWidth-1:0]   a_data;

    logic                   b_valid, b_ready;
    logic [2:0]             b_opcode, b_param;
    logic [SizeWidth-1:0]   b_size;
    logic [SourceWidth-1:0] b_source;
    logic [AddrWidth-1:0]   b_address;

    logic                   c_valid, c_ready, c_corrupt;
    logic [2:0]             c_opcode, c_param;
    logic [SizeWidth-1:0]   c_size;
    logic [SourceWidth-1:0] c_source;
    logic [AddrWidth-1:0]   c_address;
    logic [DataWidth-1:0]   c_data;

    logic                   d_valid, d_ready, d_denied, d_corrupt;
    logic [2:0]             d_opcode, d_param;
    logic [SizeWidth-1:0]   d_size;
    logic [SourceWidth-1:0] d_source;
    logic [SinkWidth-1:0]   d_sink;
    logic [DataWidth-1:0]   d_data;

    logic                   e_valid, e_ready;
    logic [SinkWidth-1:0]   e_sink;

    modport host (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
        input  a_ready,
        input  b_valid, b_opcode, b_param, b_size, b_source, b_address,
        output b_ready,
        output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_corrupt, c_data,
        input  c_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
        output d_ready,
        output e_valid, e_sink,
        input  e_ready
    );

    modport device (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt, a_data,
        output a_ready,
        output b_valid, b_opcode, b_param, b_size, b_source, b_address,
        input  b_ready,
        input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_corrupt, c_data,
        output c_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt, d_data,
        input  d_ready,
        input  e_valid, e_sink,
        output e_ready
    );
endinterface

// File: rtl/muntjac_tl_ram_device_sram.sv
// muntjac_tl_ram_sram: single-port synchronous SRAM, 1-cycle read latency, byte write enables.
module muntjac_tl_ram_sram #(
    parameter int unsigned DepthWords = 8192,
    parameter int unsigned Width      = 64,
    localparam int unsigned IdxW      = $clog2(DepthWords)
) (
    input  logic               clk_i,
    input  logic               en,
    input  logic               we,
    input  logic [Width/8-1:0] wmask,
    input  logic [IdxW-1:0]    addr,
    input  logic [Width-1:0]   wdata,
    output logic [Width-1:0]   rdata
);
    logic [Width-1:0] mem [DepthWords];

    // rdata only changes on a read, so it holds a stalled D beat steady.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < Width / 8; i++)
                    if (wmask[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/muntjac_tl_ram_device.sv
// muntjac_tl_ram_device: TL-UH responder serving Get/PutFull/PutPartial bursts from on-chip SRAM.
// Define MUNTJAC_TL_RAM_ERR_EN to deny out-of-range, oversize and unsupported requests.
module muntjac_tl_ram_device
    import muntjac_tl_ram_device_pkg::*;
#(
    parameter int unsigned          AddrWidth   = 56,
    parameter int unsigned          DataWidth   = 64,
    parameter int unsigned          SourceWidth = 4,
    parameter int unsigned          SinkWidth   = 1,
    parameter logic [AddrWidth-1:0] BaseAddr    = 'h80000000,
    parameter int unsigned          DepthWords  = 8192,
    parameter int unsigned          MaxSize     = 6
) (
    input logic        clk_i,
    input logic        rst_i,
    tl_channel.device  host
);
    localparam int unsigned IdxW = $clog2(DepthWords);

    typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_e;

    state_e                 state, state_d;
    logic [4:0]             cnt, cnt_d, req_beats;
    logic [IdxW-1:0]        idx, idx_d, req_idx, sram_addr;
    logic [SizeWidth-1:0]   size_q;
    logic [SourceWidth-1:0] source_q;
    logic [AddrWidth-1:0]   off;
    logic                   a_fire, d_fire, accept, is_put, req_read, req_err, err;
    logic                   sram_en, sram_we;

    assign off     = host.a_address - BaseAddr;
    assign req_idx = off[IdxW+2:3];
    assign is_put  = host.a_opcode == PutFullData || host.a_opcode == PutPartialData;
    assign a_fire  = host.a_valid && host.a_ready;
    assign d_fire  = host.d_valid && host.d_ready;
    assign accept  = a_fire && state == IDLE;
    // Data-less non-Get requests (only reachable when denied) carry a single A beat.
    assign req_beats = (!req_read && host.a_opcode[2]) ? 5'd1 : tl_beats(host.a_size);

`ifdef MUNTJAC_TL_RAM_ERR_EN
    assign req_read = host.a_opcode == Get;
    assign req_err  = |off[AddrWidth-1:IdxW+3] || host.a_size > SizeWidth'(MaxSize)
                      || !(is_put || req_read);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err <= 1'b0;
        else if (accept) err <= req_err;
    end

    assign host.d_denied  = err;
    assign host.d_corrupt = err && state == READ;
`else
    assign req_read       = !is_put;
    assign req_err        = 1'b0;
    assign err            = 1'b0;
    assign host.d_denied  = 1'b0;
    assign host.d_corrupt = 1'b0;

`ifndef SYNTHESIS
    a_opcode_supported: assert property (@(posedge clk_i) disable iff (rst_i)
        accept |-> (is_put || host.a_opcode == Get));
`endif
`endif

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        idx_d     = idx;
        sram_en   = 1'b0;
        sram_we   = 1'b0;
        sram_addr = idx;
        case (state)
            IDLE: if (a_fire) begin
                cnt_d     = req_beats - 5'd1;
                idx_d     = req_read ? req_idx : req_idx + 1'b1;
                sram_en   = !req_err;
                sram_we   = !req_read;
                sram_addr = req_idx;
                state_d   = req_read ? READ : (req_beats == 5'd1 ? ACK : WRITE);
            end
            WRITE: if (a_fire) begin
                sram_en = !err;
                sram_we = 1'b1;
                idx_d   = idx + 1'b1;
                cnt_d   = cnt - 5'd1;
                state_d = cnt == 5'd1 ? ACK : WRITE;
            end
            // The next beat is fetched on the handshake so it is ready the following cycle.
            READ: if (d_fire) begin
                if (cnt == 5'd0) begin
                    state_d = IDLE;
                end else begin
                    sram_en   = !err;
                    sram_addr = idx + 1'b1;
                    idx_d     = idx + 1'b1;
                    cnt_d     = cnt - 5'd1;
                end
            end
            ACK: if (d_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            size_q   <= '0;
            source_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            if (accept) begin
                size_q   <= host.a_size;
                source_q <= host.a_source;
            end
        end
    end

    muntjac_tl_ram_sram #(
        .DepthWords (DepthWords),
        .Width      (DataWidth)
    ) u_sram (
        .clk_i (clk_i),
        .en    (sram_en),
        .we    (sram_we),
        .wmask (host.a_mask),
        .addr  (sram_addr),
        .wdata (host.a_data),
        .rdata (host.d_data)
    );

    assign host.a_ready  = state == IDLE || state == WRITE;
    assign host.d_valid  = state == READ || state == ACK;
    assign host.d_opcode = state == READ ? AccessAckData : AccessAck;
    assign host.d_param  = 3'd0;
    assign host.d_size   = size_q;
    assign host.d_source = source_q;
    assign host.d_sink   = SinkWidth'(0);

    assign host.b_valid   = 1'b0;
    assign host.b_opcode  = 3'd0;
    assign host.b_param   = 3'd0;
    assign host.b_size    = '0;
    assign host.b_source  = '0;
    assign host.b_address = '0;
    assign host.c_ready   = 1'b1;
    assign host.e_ready   = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{off, host.a_param, host.a_corrupt, host.b_ready, host.c_valid,
                         host.c_opcode, host.c_param, host.c_size, host.c_source,
                         host.c_address, host.c_corrupt, host.c_data, host.e_valid, host.e_sink};
endmodule

// File: tb/tb_muntjac_tl_ram_device.sv
// tb_muntjac_tl_ram_device: directed self-checking bench for the TileLink RAM device.
module tb_muntjac_tl_ram_device;
    import muntjac_tl_ram_device_pkg::*;

    localparam logic [55:0] B    = 56'h80000000;
    localparam logic [55:0] LAST = B + 56'(8191 * 8);

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tl_channel #(.AddrWidth(56), .DataWidth(64), .SourceWidth(4), .SinkWidth(1)) bus ();

    muntjac_tl_ram_device #(
        .AddrWidth(56), .DataWidth(64), .SourceWidth(4), .SinkWidth(1),
        .BaseAddr(B), .DepthWords(8192), .MaxSize(6)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .host  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic a_send(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                          input logic [55:0] addr, input logic [63:0] data, input logic [7:0] mask);
        int n;
        bus.a_valid   = 1'b1;
        bus.a_opcode  = op;
        bus.a_size    = sz;
        bus.a_source  = src;
        bus.a_address = addr;
        bus.a_data    = data;
        bus.a_mask    = mask;
        n = 0;
        @(negedge clk);
        while (!bus.a_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("a_accept", bus.a_ready, 1);
        check("no_d_on_accept", bus.d_valid, 0);
        @(posedge clk);
        #1 bus.a_valid = 1'b0;
    endtask

    task automatic d_recv(input string tag, input logic [2:0] op, input logic [3:0] src,
                          input logic [2:0] sz, input logic chk, input logic [63:0] data,
                          input logic den, input logic cor);
        @(negedge clk);
        check({tag, ".valid"}, bus.d_valid, 1);
        check({tag, ".opcode"}, bus.d_opcode, op);
        check({tag, ".source"}, bus.d_source, src);
        check({tag, ".size"}, bus.d_size, sz);
        if (chk) check({tag, ".data"}, bus.d_data, data);
        check({tag, ".denied"}, bus.d_denied, den);
        check({tag, ".corrupt"}, bus.d_corrupt, cor);
        check({tag, ".param"}, bus.d_param, 0);
        check({tag, ".sink"}, bus.d_sink, 0);
        check({tag, ".a_ready"}, bus.a_ready, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pat;
        int beat, cyc;
        pat = 4'b1001;
        {bus.a_valid, bus.a_opcode, bus.a_param, bus.a_size, bus.a_source, bus.a_address} = '0;
        {bus.a_mask, bus.a_corrupt, bus.a_data, bus.b_ready} = '0;
        {bus.c_valid, bus.c_opcode, bus.c_param, bus.c_size, bus.c_source} = '0;
        {bus.c_address, bus.c_corrupt, bus.c_data, bus.e_valid, bus.e_sink} = '0;
        bus.d_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        check("reset.a_ready", bus.a_ready, 1);
        check("reset.d_valid", bus.d_valid, 0);
        @(posedge clk);
        #1;

        a_send(PutFullData, 3, 3, B + 56'h10, 64'h1122334455667788, 8'hFF);
        d_recv("put1", AccessAck, 3, 3, 0, 0, 0, 0);
        a_send(Get, 3, 5, B + 56'h10, 0, 8'hFF);
        d_recv("get1", AccessAckData, 5, 3, 1, 64'h1122334455667788, 0, 0);

        a_send(PutFullData, 3, 1, B + 56'h20, 0, 8'hFF);
        d_recv("clr", AccessAck, 1, 3, 0, 0, 0, 0);
        a_send(PutPartialData, 3, 1, B + 56'h20, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        d_recv("partial", AccessAck, 1, 3, 0, 0, 0, 0);
        a_send(Get, 3, 2, B + 56'h20, 0, 8'hFF);
        d_recv("get_partial", AccessAckData, 2, 3, 1, 64'h00000000AAAAAAAA, 0, 0);

        for (int i = 0; i < 8; i++) a_send(PutFullData, 6, 7, B + 56'h100, 64'(i), 8'hFF);
        d_recv("bput", AccessAck, 7, 6, 0, 0, 0, 0);

        a_send(Get, 6, 9, B + 56'h100, 0, 8'hFF);
        beat = 0;
        cyc = 0;
        while (beat < 8 && cyc < 64) begin
            bus.d_ready = pat[cyc % 4];
            @(negedge clk);
            check("bget.valid", bus.d_valid, 1);
            check("bget.data", bus.d_data, 64'(beat));
            check("bget.source", bus.d_source, 9);
            check("bget.size", bus.d_size, 6);
            check("bget.a_ready", bus.a_ready, 0);
            @(posedge clk);
            if (bus.d_ready) beat++;
            #1 cyc++;
        end
        bus.d_ready = 1'b1;
        check("bget.beats", 64'(beat), 8);
        @(negedge clk);
        check("bget.done_valid", bus.d_valid, 0);
        check("bget.done_a_ready", bus.a_ready, 1);
        @(posedge clk);
        #1;

        a_send(PutFullData, 3, 1, LAST, 64'hDEADBEEF00000001, 8'hFF);
        d_recv("wlast", AccessAck, 1, 3, 0, 0, 0, 0);
        a_send(PutFullData, 3, 1, B, 64'hCAFEF00D00000002, 8'hFF);
        d_recv("wfirst", AccessAck, 1, 3, 0, 0, 0, 0);
        a_send(Get, 4, 4, LAST, 0, 8'hFF);
        d_recv("wrap0", AccessAckData, 4, 4, 1, 64'hDEADBEEF00000001, 0, 0);
        d_recv("wrap1", AccessAckData, 4, 4, 1, 64'hCAFEF00D00000002, 0, 0);

        a_send(Get, 6, 6, B + 56'h100, 0, 8'hFF);
        for (int i = 0; i < 4; i++) d_recv("rget", AccessAckData, 6, 6, 1, 64'(i), 0, 0);
        rst_i = 1'b1;
        #1 check("rst.d_valid_now", bus.d_valid, 0);
        @(posedge clk);
        #1 rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst.a_ready", bus.a_ready, 1);
            check("rst.no_beats", bus.d_valid, 0);
            @(posedge clk);
            #1;
        end

`ifdef MUNTJAC_TL_RAM_ERR_EN
        a_send(Get, 3, 2, B - 56'd8, 0, 8'hFF);
        d_recv("err_get", AccessAckData, 2, 3, 0, 0, 1, 1);
        a_send(ArithmeticData, 3, 3, B + 56'h10, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        d_recv("err_arith", AccessAck, 3, 3, 0, 0, 1, 0);
        a_send(Get, 3, 4, B + 56'h10, 0, 8'hFF);
        d_recv("err_unchanged", AccessAckData, 4, 3, 1, 64'h1122334455667788, 0, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
